// File: rtl/zero_count_accumulator.sv
// -----------------------------------------------------------------------------
// zero_count_accumulator
//
// Frame-level accumulator fed by zero_count_function. Each accepted beat
// carries one byte's zero count (legal 0..8). Counts are summed over a frame
// of FRAME_LEN bytes, or fewer when flush closes the frame early. The
// per-frame maximum, byte count and an illegal-count flag are tracked as
// well, and one result record per frame is offered on a valid/ready output.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. A producer holds valid and its payload
// stable until that edge; ready may change freely and never waits on valid.
//
// Parameters
//   FRAME_LEN  bytes per full frame, 1..255
//   SUM_W      width of out_sum, 2**SUM_W > 8*FRAME_LEN
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   in_count holds a zero count
//   in_ready   beat accepted when in_valid && in_ready (0 while rst is high)
//   in_count   zero count, legal 0..8; 9..15 clamped to 8 and flagged
//   flush      close the current (non-empty) frame early
//   out_valid  result record valid
//   out_ready  consumer takes the record when out_valid && out_ready
//   out_sum    total zero count of the frame
//   out_max    largest clamped count in the frame
//   out_len    bytes in the frame, 1..FRAME_LEN
//   out_err    at least one beat of the frame had in_count > 8
//   dbg_state  current FSM state (0 = ACCUM, 1 = DONE)
// -----------------------------------------------------------------------------
module zero_count_accumulator #(
   parameter int FRAME_LEN = 16,
   parameter int SUM_W     = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_count,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SUM_W-1:0] out_sum,
   output logic [3:0]       out_max,
   output logic [7:0]       out_len,
   output logic             out_err,
   output logic             dbg_state
);

   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } state_t;

   state_t state, next_state;

   logic [SUM_W-1:0] acc_sum;
   logic [3:0]       acc_max;
   logic [7:0]       acc_len;
   logic             acc_err;

   // Values the accumulators would take after this cycle's beat (if any).
   // A closing frame is loaded from these so the closing beat is included.
   logic             beat;
   logic [3:0]       clamped;
   logic [SUM_W-1:0] post_sum;
   logic [3:0]       post_max;
   logic [7:0]       post_len;
   logic             post_err;
   logic             frame_close;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) state <= ACCUM;
      else     state <= next_state;
   end

   // ---------------------------------------------------------------------------
   // Next state, handshake outputs and post-beat accumulator values
   // ---------------------------------------------------------------------------
   always_comb begin
      next_state  = state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      beat        = 1'b0;
      clamped     = (in_count > 4'd8) ? 4'd8 : in_count;
      post_sum    = acc_sum;
      post_max    = acc_max;
      post_len    = acc_len;
      post_err    = acc_err;
      frame_close = 1'b0;

      case (state)
         ACCUM: begin
            // Held low during reset so nothing is taken while rst is high.
            in_ready = !rst;
            beat     = in_valid && in_ready;
            if (beat) begin
               post_sum = acc_sum + SUM_W'(clamped);
               post_max = (clamped > acc_max) ? clamped : acc_max;
               post_len = acc_len + 8'd1;
               post_err = acc_err | (in_count > 4'd8);
            end
            // acc_len stays below FRAME_LEN in ACCUM, so post_len cannot wrap.
            // An empty flush (no prior beats, none this cycle) is ignored.
            frame_close = (beat && (post_len == 8'(FRAME_LEN)))
                        || (flush && (post_len != 8'd0));
            if (frame_close) next_state = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) next_state = ACCUM;
         end
         default: next_state = ACCUM;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Accumulators and the output record
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_sum <= '0;
         acc_max <= '0;
         acc_len <= '0;
         acc_err <= 1'b0;
         out_sum <= '0;
         out_max <= '0;
         out_len <= '0;
         out_err <= 1'b0;
      end else if (frame_close) begin
         out_sum <= post_sum;
         out_max <= post_max;
         out_len <= post_len;
         out_err <= post_err;
         acc_sum <= '0;
         acc_max <= '0;
         acc_len <= '0;
         acc_err <= 1'b0;
      end else begin
         // Outside ACCUM the post_* values equal the current accumulators,
         // and the record registers only change on a frame close, which
         // keeps out_* stable for the whole DONE period.
         acc_sum <= post_sum;
         acc_max <= post_max;
         acc_len <= post_len;
         acc_err <= post_err;
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_zero_count_accumulator.sv
// -----------------------------------------------------------------------------
// tb_zero_count_accumulator
//
// Directed scenarios followed by randomized traffic. A behavioural model
// holds the bytes of the open frame in a queue and, when the frame closes,
// derives the record (sum / max / length / error) from that list. Closed
// records wait in exp_q until the consumer takes them; while exp_q is not
// empty the DUT must present exp_q[0] with out_valid high and in_ready low.
// -----------------------------------------------------------------------------
module tb_zero_count_accumulator;

   localparam int FRAME_LEN = 16;
   localparam int SUM_W     = 11;
   localparam int REC_W     = SUM_W + 4 + 8 + 1;

   // ---------------------------------------------------------------------------
   // Clock / reset / DUT
   // ---------------------------------------------------------------------------
   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_count;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [SUM_W-1:0] out_sum;
   logic [3:0]       out_max;
   logic [7:0]       out_len;
   logic             out_err;
   logic             dbg_state;

   always #5 clk = ~clk;

   zero_count_accumulator #(
      .FRAME_LEN (FRAME_LEN),
      .SUM_W     (SUM_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_count  (in_count),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_max   (out_max),
      .out_len   (out_len),
      .out_err   (out_err),
      .dbg_state (dbg_state)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard state
   // ---------------------------------------------------------------------------
   logic [REC_W-1:0] exp_q[$];     // closed records not yet taken
   int               frame_q[$];   // raw counts of the open frame
   int               checks = 0;
   int               errors = 0;
   int               n_taken = 0;  // records taken from the DUT
   logic [REC_W-1:0] last_taken;   // DUT record at the last handshake

   function automatic logic [REC_W-1:0] pack(input int s, input int m,
                                             input int l, input bit e);
      return {SUM_W'(s), 4'(m), 8'(l), e};
   endfunction

   // Record of a finished frame, straight from its list of raw counts.
   function automatic logic [REC_W-1:0] frame_record(input int cnts[$]);
      int s = 0;
      int m = 0;
      bit e = 1'b0;
      foreach (cnts[i]) begin
         int c = (cnts[i] > 8) ? 8 : cnts[i];
         s += c;
         if (c > m) m = c;
         if (cnts[i] > 8) e = 1'b1;
      end
      return pack(s, m, cnts.size(), e);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Driver: one clock cycle. Inputs are applied just after a rising edge,
   // outputs are checked on the falling edge, then the model advances for
   // the next rising edge.
   // ---------------------------------------------------------------------------
   task automatic step(input bit v, input int cnt, input bit fl,
                       input bit ordy, input bit r);
      bit pending;
      rst       = r;
      in_valid  = v;
      in_count  = 4'(cnt);
      flush     = fl;
      out_ready = ordy;
      @(negedge clk);

      pending = (exp_q.size() != 0);
      chk("in_ready", 32'(in_ready), 32'(!r && !pending));
      chk("out_valid", 32'(out_valid), 32'(pending));
      if (pending)
         chk("record", 32'({out_sum, out_max, out_len, out_err}), 32'(exp_q[0]));

      if (r) begin
         exp_q.delete();
         frame_q.delete();
      end else if (pending) begin
         if (ordy) begin
            last_taken = {out_sum, out_max, out_len, out_err};
            n_taken++;
            void'(exp_q.pop_front());
         end
      end else begin
         if (v) frame_q.push_back(cnt);
         if ((v && frame_q.size() == FRAME_LEN) || (fl && frame_q.size() > 0)) begin
            exp_q.push_back(frame_record(frame_q));
            frame_q.delete();
         end
      end

      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      int base;
      rst = 1'b1; in_valid = 1'b0; in_count = 4'd0; flush = 1'b0; out_ready = 1'b0;

      // Reset, then idle.
      step(0, 0, 0, 0, 1);
      step(1, 5, 1, 1, 1);
      chk("rst_out_sum", 32'(out_sum), 32'd0);
      chk("rst_out_max", 32'(out_max), 32'd0);
      chk("rst_out_len", 32'(out_len), 32'd0);
      chk("rst_out_err", 32'(out_err), 32'd0);
      for (int i = 0; i < 3; i++) step(0, $urandom_range(0, 15), 0, 1, 0);

      // Full frame: 0..8,0..6 back to back, consumer always ready.
      for (int i = 0; i < FRAME_LEN; i++) step(1, i % 9, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      chk("full_frame", 32'(last_taken), 32'(pack(57, 8, 16, 0)));
      chk("full_frame_n", n_taken, 1);

      // Backpressure: 16 beats of 3, consumer stalls 5 cycles with beats offered.
      for (int i = 0; i < FRAME_LEN; i++) step(1, 3, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(1, 5, 0, 0, 0);
      step(1, 5, 0, 1, 0);
      chk("backpressure", 32'(last_taken), 32'(pack(48, 3, 16, 0)));

      // Flush boundaries: 5,7,2 with flush on the last beat; flush in DONE;
      // then an empty flush that must emit nothing.
      step(1, 5, 0, 1, 0);
      step(1, 7, 0, 1, 0);
      step(1, 2, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 1, 0);
      chk("flush_rec", 32'(last_taken), 32'(pack(14, 7, 3, 0)));
      base = n_taken;
      step(0, 0, 1, 1, 0);
      step(0, 0, 0, 1, 0);
      chk("empty_flush", n_taken, base);

      // Illegal count, then a clean frame.
      step(1, 12, 0, 1, 0);
      for (int i = 0; i < FRAME_LEN - 1; i++) step(1, 1, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      chk("illegal_rec", 32'(last_taken), 32'(pack(23, 8, 16, 1)));
      for (int i = 0; i < FRAME_LEN; i++) step(1, 2, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      chk("clean_after_err", 32'(last_taken), 32'(pack(32, 2, 16, 0)));

      // Reset mid-frame discards the partial frame.
      base = n_taken;
      for (int i = 0; i < 10; i++) step(1, 4, 0, 1, 0);
      step(1, 4, 0, 1, 1);
      for (int i = 0; i < FRAME_LEN; i++) step(1, 2, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      chk("rst_mid_n", n_taken, base + 1);
      chk("rst_mid_rec", 32'(last_taken), 32'(pack(32, 2, 16, 0)));

      // Randomized traffic, including illegal counts and idle-cycle junk.
      for (int i = 0; i < 600; i++) begin
         int c = ($urandom_range(0, 7) == 0) ? $urandom_range(9, 15)
                                             : $urandom_range(0, 8);
         step($urandom_range(0, 3) != 0, c, $urandom_range(0, 9) == 0,
              $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0);
      end

      // Drain any pending record within a bounded number of cycles.
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(0, 0, 0, 1, 0);
      chk("drain", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
